alu_arb_ctrl: RTL

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_pkg.sv | 34 +++
 rtl/alu_rr_pick.sv | 24 ++
 rtl/alu_arb_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter/controller:
//   - N_DEFAULT   : default operand width of the shared ALU datapath
//   - state_e     : controller FSM state encoding
//   - OP_*        : opcode constants for arithmetic (mode=1) and logic (mode=0)
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_e;

   // Arithmetic opcodes (mode = 1)
   localparam logic [1:0] OP_TRANSFER = 2'b00;
   localparam logic [1:0] OP_ADD      = 2'b01;
   localparam logic [1:0] OP_SUB      = 2'b10;
   localparam logic [1:0] OP_RSUB     = 2'b11;

   // Logic opcodes (mode = 0)
   localparam logic [1:0] OP_AND      = 2'b00;
   localparam logic [1:0] OP_OR       = 2'b01;
   localparam logic [1:0] OP_XOR      = 2'b10;
   localparam logic [1:0] OP_XNOR     = 2'b11;

   // Last-grant value after reset: "req1 was granted last", so req0 wins the first tie.
   localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Two-way round-robin selection.
//   valid[1:0] : requester valid bits
//   last       : index of the requester granted most recently
//   grant[1:0] : one-hot winner, or zero when nothing is valid
// -----------------------------------------------------------------------------
module alu_rr_pick
   import alu_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      // On a tie the requester that was not granted last wins.
      if (valid == 2'b11) begin
         grant = (last == LAST_RESET) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arb_ctrl.sv
// -----------------------------------------------------------------------------
// alu_arb_ctrl
// Arbitrates two requesters onto a shared registered ALU and returns the result
// tagged with the requester id. One operation is in flight at a time:
// IDLE (accept) -> ISSUE (drive ALU) -> WAIT (capture result) -> RESP (handshake).
//
// Ports:
//   Clk, rst                     : clock (posedge) and async active-high reset
//   reqX_valid / reqX_ready      : request handshake, X = 0,1 (ready is combinational)
//   reqX_a, reqX_b, reqX_cin,
//   reqX_oper, reqX_mode         : operation fields (mode 1 = arithmetic, 0 = logic)
//   alu_a, alu_b, alu_cin,
//   alu_oper, alu_mode           : registered drive to the ALU
//   alu_sum, alu_cout            : registered ALU result
//   resp_valid / resp_ready      : response handshake
//   resp_id, resp_sum, resp_cout : response payload
//
// Build option ALU_ARB_CNT_EN: adds 8-bit wrapping acceptance counters
//   grant_cnt0 / grant_cnt1.
// -----------------------------------------------------------------------------
module alu_arb_ctrl
   import alu_arb_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         Clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_cin,
   input  logic [1:0]   req0_oper,
   input  logic         req0_mode,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_cin,
   input  logic [1:0]   req1_oper,
   input  logic         req1_mode,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic         alu_cin,
   output logic [1:0]   alu_oper,
   output logic         alu_mode,
   input  logic [N-1:0] alu_sum,
   input  logic         alu_cout,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [N-1:0] resp_sum,
   output logic         resp_cout
`ifdef ALU_ARB_CNT_EN
   ,
   output logic [7:0]   grant_cnt0,
   output logic [7:0]   grant_cnt1
`endif
);

   state_e       state_q, state_d;
   logic         last_q, last_d;
   logic         lat_id_q, lat_id_d;
   logic         lat_mode_q, lat_mode_d;
   logic [N-1:0] alu_a_q, alu_a_d;
   logic [N-1:0] alu_b_q, alu_b_d;
   logic         alu_cin_q, alu_cin_d;
   logic [1:0]   alu_oper_q, alu_oper_d;
   logic         alu_mode_q, alu_mode_d;
   logic         resp_valid_q, resp_valid_d;
   logic         resp_id_q, resp_id_d;
   logic [N-1:0] resp_sum_q, resp_sum_d;
   logic         resp_cout_q, resp_cout_d;
   logic [1:0]   grant;
   logic         accept;

   alu_rr_pick u_pick (
      .valid ({req1_valid, req0_valid}),
      .last  (last_q),
      .grant (grant)
   );

   // Grants are only offered in IDLE; gating with rst keeps ready low while reset is held.
   assign accept     = (state_q == IDLE) && (grant != 2'b00) && !rst;
   assign req0_ready = accept && grant[0];
   assign req1_ready = accept && grant[1];

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      lat_id_d     = lat_id_q;
      lat_mode_d   = lat_mode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cin_d    = alu_cin_q;
      alu_oper_d   = alu_oper_q;
      alu_mode_d   = alu_mode_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_sum_d   = resp_sum_q;
      resp_cout_d  = resp_cout_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               // The ALU drive registers double as the latched operand fields,
               // so they present the operation during the ISSUE cycle.
               state_d    = ISSUE;
               last_d     = grant[1];
               lat_id_d   = grant[1];
               lat_mode_d = grant[1] ? req1_mode : req0_mode;
               alu_a_d    = grant[1] ? req1_a    : req0_a;
               alu_b_d    = grant[1] ? req1_b    : req0_b;
               alu_cin_d  = grant[1] ? req1_cin  : req0_cin;
               alu_oper_d = grant[1] ? req1_oper : req0_oper;
               alu_mode_d = grant[1] ? req1_mode : req0_mode;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Logic ops leave the ALU carry untouched, so it carries no meaning here.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_id_d    = lat_id_q;
            resp_sum_d   = alu_sum;
            resp_cout_d  = lat_mode_q & alu_cout;
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_q       <= LAST_RESET;
         lat_id_q     <= 1'b0;
         lat_mode_q   <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         alu_oper_q   <= 2'b00;
         alu_mode_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_sum_q   <= '0;
         resp_cout_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         lat_id_q     <= lat_id_d;
         lat_mode_q   <= lat_mode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         alu_oper_q   <= alu_oper_d;
         alu_mode_q   <= alu_mode_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_sum_q   <= resp_sum_d;
         resp_cout_q  <= resp_cout_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign alu_oper   = alu_oper_q;
   assign alu_mode   = alu_mode_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_sum   = resp_sum_q;
   assign resp_cout  = resp_cout_q;

`ifdef ALU_ARB_CNT_EN
   logic [7:0] grant_cnt0_q, grant_cnt0_d;
   logic [7:0] grant_cnt1_q, grant_cnt1_d;

   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      // 8-bit add wraps 255 -> 0 naturally.
      if (req0_ready && req0_valid) grant_cnt0_d = grant_cnt0_q + 8'd1;
      if (req1_ready && req1_valid) grant_cnt1_d = grant_cnt1_q + 8'd1;
   end

   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         grant_cnt0_q <= 8'd0;
         grant_cnt1_q <= 8'd0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
